// File: rtl/easyaxi_rd_slv_pkg.sv
// Shared AXI widths, encodings and request helpers for the EasyAXI read slave.
// The write slave reuses the same request struct and burst-legality check.
package easyaxi_rd_slv_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OK     = 2'b00;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_SLVERR = 2'b10;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_1B = 3'd0;
  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_2B = 3'd1;
  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_4B = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } ar_req_t;

  // Misalignment, oversize, the reserved burst code and illegal wrap lengths
  // all answer SLVERR; the burst itself still runs to completion.
  function automatic logic ar_is_err(input ar_req_t req, input int unsigned max_size);
    logic [AXI_ADDR_W-1:0] mask;
    logic                  err;
    mask = (AXI_ADDR_W'(1) << req.size) - AXI_ADDR_W'(1);
    err  = 1'b0;
    if ((req.addr & mask) != '0)
      err = 1'b1;
    if (32'(req.size) > max_size)
      err = 1'b1;
    if (req.burst == AXI_BURST_RSVD)
      err = 1'b1;
    if ((req.burst == AXI_BURST_WRAP) &&
        !(req.len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/easyaxi_rd_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Shared by the read and write slaves; the reserved burst code steps like INCR.
module easyaxi_rd_addr_gen
  import easyaxi_rd_slv_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0]  i_addr,
  input  logic [AXI_LEN_W-1:0]   i_len,
  input  logic [AXI_SIZE_W-1:0]  i_size,
  input  logic [AXI_BURST_W-1:0] i_burst,
  output logic [AXI_ADDR_W-1:0]  o_next_addr
);

  logic [AXI_ADDR_W-1:0] w_step;
  logic [AXI_ADDR_W-1:0] w_incr;
  logic [AXI_ADDR_W-1:0] w_wrap_len;
  logic [AXI_ADDR_W-1:0] w_boundary;
  logic [AXI_ADDR_W-1:0] w_wrap_top;

  assign w_step     = AXI_ADDR_W'(1) << i_size;
  assign w_incr     = i_addr + w_step;
  assign w_wrap_len = (AXI_ADDR_W'(i_len) + AXI_ADDR_W'(1)) << i_size;
  assign w_boundary = i_addr & ~(w_wrap_len - AXI_ADDR_W'(1));
  // Both sides wrap modulo 2^AXI_ADDR_W, so a window at the top of the map still folds.
  assign w_wrap_top = w_boundary + w_wrap_len;

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      AXI_BURST_FIXED: o_next_addr = i_addr;
      AXI_BURST_WRAP:  o_next_addr = (w_incr == w_wrap_top) ? w_boundary : w_incr;
      default:         o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/easyaxi_rd_slv.sv
// EasyAXI read slave: one outstanding AR, RD_LAT cycles of latency, then
// arlen+1 beats whose data is the beat address; protocol faults answer SLVERR.
module easyaxi_rd_slv
  import easyaxi_rd_slv_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int MAX_SIZE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   axi_slv_arvalid,
  output logic                   axi_slv_arready,
  input  logic [AXI_ID_W-1:0]    axi_slv_arid,
  input  logic [AXI_ADDR_W-1:0]  axi_slv_araddr,
  input  logic [AXI_LEN_W-1:0]   axi_slv_arlen,
  input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
  output logic                   axi_slv_rvalid,
  input  logic                   axi_slv_rready,
  output logic [AXI_ID_W-1:0]    axi_slv_rid,
  output logic [AXI_DATA_W-1:0]  axi_slv_rdata,
  output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                   axi_slv_rlast
);

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  rd_state_e             r_state;
  rd_state_e             w_next_state;
  ar_req_t               r_req;
  logic                  r_err;
  logic [3:0]            r_lat_cnt;
  logic [AXI_LEN_W-1:0]  r_beat_cnt;

  ar_req_t               w_ar_req;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_last_beat;
  logic [AXI_ADDR_W-1:0] w_next_addr;

  assign w_ar_req = '{id:    axi_slv_arid,
                      addr:  axi_slv_araddr,
                      len:   axi_slv_arlen,
                      size:  axi_slv_arsize,
                      burst: axi_slv_arburst};

  assign w_ar_hs     = axi_slv_arvalid & axi_slv_arready;
  assign w_r_hs      = axi_slv_rvalid & axi_slv_rready;
  assign w_last_beat = (r_beat_cnt == r_req.len);

  easyaxi_rd_addr_gen u_addr_gen (
    .i_addr      (r_req.addr),
    .i_len       (r_req.len),
    .i_size      (r_req.size),
    .i_burst     (r_req.burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state    = r_state;
    axi_slv_arready = 1'b0;
    axi_slv_rvalid  = 1'b0;
    axi_slv_rlast   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        axi_slv_arready = 1'b1;
        if (axi_slv_arvalid)
          w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_lat_cnt == 4'd0)
          w_next_state = ST_DATA;
      end
      ST_DATA: begin
        axi_slv_rvalid = 1'b1;
        axi_slv_rlast  = w_last_beat;
        // Going back through IDLE keeps arready low in the last-beat cycle.
        if (axi_slv_rready && w_last_beat)
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req      <= '0;
      r_err      <= 1'b0;
      r_lat_cnt  <= 4'd0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_req      <= w_ar_req;
            r_err      <= ar_is_err(w_ar_req, MAX_SIZE);
            r_lat_cnt  <= LAT_LOAD;
            r_beat_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt != 4'd0)
            r_lat_cnt <= r_lat_cnt - 4'd1;
        end
        ST_DATA: begin
          // r_req.addr is the live beat address and doubles as the rdata source.
          if (w_r_hs) begin
            if (w_last_beat) begin
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + AXI_LEN_W'(1);
              r_req.addr <= w_next_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign axi_slv_rid   = r_req.id;
  assign axi_slv_rdata = AXI_DATA_W'(r_req.addr);
  assign axi_slv_rresp = r_err ? AXI_RESP_SLVERR : AXI_RESP_OK;

  a_r_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (axi_slv_rvalid && !axi_slv_rready) |=>
      (axi_slv_rvalid && $stable(axi_slv_rdata) && $stable(axi_slv_rid) &&
       $stable(axi_slv_rresp) && $stable(axi_slv_rlast)));

  a_one_channel: assert property (@(posedge clk) disable iff (!rst_n)
    !(axi_slv_rvalid && axi_slv_arready));

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Scoreboard bench for easyaxi_rd_slv: expected R beats are queued when each
// AR is issued and compared as the slave presents them.
module tb_easyaxi_rd_slv;
  import easyaxi_rd_slv_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int MAX_SIZE = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   arvalid;
  logic                   arready;
  logic [AXI_ID_W-1:0]    arid;
  logic [AXI_ADDR_W-1:0]  araddr;
  logic [AXI_LEN_W-1:0]   arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic                   rvalid;
  logic                   rready;
  logic [AXI_ID_W-1:0]    rid;
  logic [AXI_DATA_W-1:0]  rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    bit          chk_data;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  easyaxi_rd_slv #(.RD_LAT(RD_LAT), .MAX_SIZE(MAX_SIZE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arvalid (arvalid),
    .axi_slv_arready (arready),
    .axi_slv_arid    (arid),
    .axi_slv_araddr  (araddr),
    .axi_slv_arlen   (arlen),
    .axi_slv_arsize  (arsize),
    .axi_slv_arburst (arburst),
    .axi_slv_rvalid  (rvalid),
    .axi_slv_rready  (rready),
    .axi_slv_rid     (rid),
    .axi_slv_rdata   (rdata),
    .axi_slv_rresp   (rresp),
    .axi_slv_rlast   (rlast)
  );

  function automatic logic [31:0] model_next(input logic [31:0] a, input int len,
                                             input int size, input int burst);
    longint step, wl, base, off;
    step = longint'(1) << size;
    if (burst == 0) return a;
    if (burst == 2) begin
      wl   = longint'(len + 1) * step;
      base = longint'(a) - (longint'(a) % wl);
      off  = (longint'(a) - base + step) % wl;
      return 32'(base + off);
    end
    return 32'(longint'(a) + step);
  endfunction

  function automatic bit model_err(input logic [31:0] a, input int len,
                                   input int size, input int burst);
    if ((longint'(a) % (longint'(1) << size)) != 0) return 1'b1;
    if (size > MAX_SIZE) return 1'b1;
    if (burst == 3) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_expected(input int id, input logic [31:0] a, input int len,
                               input int size, input int burst);
    beat_t       b;
    bit          e;
    logic [31:0] cur;
    e   = model_err(a, len, size, burst);
    cur = a;
    for (int i = 0; i <= len; i++) begin
      b.id       = 4'(id);
      b.data     = cur;
      b.resp     = e ? 2'b10 : 2'b00;
      b.last     = (i == len);
      b.chk_data = !(burst == 3 || (burst == 2 && e));
      exp_q.push_back(b);
      cur = model_next(cur, len, size, burst);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the AR handshake edge.
  task automatic send_ar(input int id, input logic [31:0] a, input int len,
                         input int size, input int burst, input bit keep);
    int cnt;
    arid    = 4'(id);
    araddr  = a;
    arlen   = 8'(len);
    arsize  = 3'(size);
    arburst = 2'(burst);
    arvalid = 1'b1;
    cnt     = 0;
    while (arready !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_accept id=%0d: arready=%b rvalid=%b, required arready=1 rvalid=0",
               id, arready, rvalid);
    end
    push_expected(id, a, len, size, burst);
    @(posedge clk);
    @(negedge clk);
    if (!keep) arvalid = 1'b0;
  endtask

  // rmode 0: rready always 1; rmode 1: rready toggles 1,0,1,0 while rvalid.
  task automatic collect(input int rmode, input string tag);
    int edges, first;
    bit tg;
    edges = 0;
    first = 1;
    tg    = 1'b1;
    while (exp_q.size() > 0 && edges < 300) begin
      if (rvalid === 1'b1) begin
        if (first) begin
          first = 0;
          n_checks++;
          if (edges != RD_LAT) begin
            n_fail++;
            $display("FAIL %s latency: first rvalid after %0d edges, required %0d",
                     tag, edges, RD_LAT);
          end
        end
        rready = (rmode == 0) ? 1'b1 : tg;
        tg     = ~tg;
        n_checks++;
        if (rid !== exp_q[0].id || rresp !== exp_q[0].resp || rlast !== exp_q[0].last ||
            arready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s beat ctl: rid=%0d rresp=%0d rlast=%b arready=%b, required rid=%0d rresp=%0d rlast=%b arready=0",
                   tag, rid, rresp, rlast, arready, exp_q[0].id, exp_q[0].resp, exp_q[0].last);
        end
        if (exp_q[0].chk_data) begin
          n_checks++;
          if (rdata !== exp_q[0].data) begin
            n_fail++;
            $display("FAIL %s rdata: got 0x%08h, required 0x%08h", tag, rdata, exp_q[0].data);
          end
        end
        if (rready) void'(exp_q.pop_front());
      end else begin
        rready = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    rready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d beats outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s post_burst: rvalid=%b arready=%b, required rvalid=0 arready=1",
               tag, rvalid, arready);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    arid    = '0;
    araddr  = '0;
    arlen   = '0;
    arsize  = '0;
    arburst = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || rlast !== 1'b0 ||
        rid !== '0 || rdata !== '0 || rresp !== '0) begin
      n_fail++;
      $display("FAIL reset_values: arready=%b rvalid=%b rlast=%b rid=%0d rdata=0x%h rresp=%0d, required 1 0 0 0 0x0 0",
               arready, rvalid, rlast, rid, rdata, rresp);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    send_ar(3, 32'h0, 0, 2, 1, 1'b0);
    collect(0, "single");
  endtask

  task automatic test_incr_toggle();
    send_ar(1, 32'h10, 3, 2, 1, 1'b0);
    collect(1, "incr_toggle");
  endtask

  task automatic test_wrap();
    send_ar(2, 32'h8, 3, 2, 2, 1'b0);
    collect(0, "wrap");
    send_ar(9, 32'h34, 7, 2, 2, 1'b0);
    collect(1, "wrap8");
  endtask

  task automatic test_fixed();
    send_ar(8, 32'h30, 2, 2, 0, 1'b0);
    collect(0, "fixed");
  endtask

  task automatic test_errors();
    send_ar(10, 32'h1, 1, 2, 1, 1'b0);
    collect(0, "err_misalign");
    send_ar(4, 32'h20, 2, 2, 2, 1'b0);
    collect(0, "err_wrap_len");
    send_ar(6, 32'h40, 1, 3, 1, 1'b0);
    collect(0, "err_size");
    send_ar(7, 32'h50, 1, 2, 3, 1'b0);
    collect(1, "err_rsvd");
  endtask

  task automatic test_incr_addr_wrap();
    send_ar(11, 32'hFFFF_FFF8, 3, 2, 1, 1'b0);
    collect(0, "incr_addr_wrap");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      send_ar(i, (i >= 10) ? 32'(i * 16 + 1) : 32'(i * 16), i % 4, 2, 1, 1'b1);
      if (i == 11) begin
        arvalid = 1'b0;
      end else begin
        arid    = 4'(i + 1);
        araddr  = (i + 1 >= 10) ? 32'((i + 1) * 16 + 1) : 32'((i + 1) * 16);
        arlen   = 8'((i + 1) % 4);
      end
      collect(0, "back_to_back");
    end
  endtask

  task automatic test_reset_mid_burst();
    int cnt;
    send_ar(5, 32'h100, 7, 2, 1, 1'b0);
    cnt = 0;
    while (rvalid !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_q[0].data) begin
      n_fail++;
      $display("FAIL rst_mid beat0: rvalid=%b rdata=0x%h, required 1 0x%h",
               rvalid, rdata, exp_q[0].data);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h104) begin
      n_fail++;
      $display("FAIL rst_mid beat1: rvalid=%b rdata=0x%h, required 1 0x104", rvalid, rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0 ||
        rdata !== '0 || rid !== '0 || rresp !== '0) begin
      n_fail++;
      $display("FAIL rst_mid async: rvalid=%b arready=%b rlast=%b rdata=0x%h rid=%0d rresp=%0d, required 0 1 0 0x0 0 0",
               rvalid, arready, rlast, rdata, rid, rresp);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid release: rvalid=%b arready=%b, required 0 1", rvalid, arready);
      end
    end
    send_ar(12, 32'h200, 1, 2, 1, 1'b0);
    collect(0, "after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_incr_toggle();
    test_wrap();
    test_fixed();
    test_errors();
    test_incr_addr_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
